// File: rtl/pwm_key_sequencer_pkg.sv
// Shared helpers for the PWM key front-end.
// get_width(n) is the bit width needed to hold the values 0..n-1.
package pwm_key_sequencer_pkg;

  function automatic int get_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_key_sequencer_if.sv
// Button inputs and step/level outputs between the key sequencer and its PWM consumer.
// The sequencer takes the master side; the PWM block (or a bench) takes the slave side.
interface pwm_key_sequencer_if #(
  parameter int W = 4
);
  logic         btn_up_n;
  logic         btn_down_n;
  logic         key_up;
  logic         key_down;
  logic [W-1:0] level;
  logic         sweep_active;

  modport master (
    input  btn_up_n,
    input  btn_down_n,
    output key_up,
    output key_down,
    output level,
    output sweep_active
  );

  modport slave (
    output btn_up_n,
    output btn_down_n,
    input  key_up,
    input  key_down,
    input  level,
    input  sweep_active
  );
endinterface

// File: rtl/pwm_key_sequencer_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one active-low button.
// The pressed flag flips only after DEBOUNCE_CYC consecutive cycles of disagreement.
module key_debounce
  import pwm_key_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);
  localparam int CW = get_width(DEBOUNCE_CYC);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          pressed_reg;

  // Synchronizer stores the pressed sense, so reset means released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg    <= '0;
      cnt_reg     <= '0;
      pressed_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], ~btn_n};
      if (sync_reg[1] != pressed_reg) begin
        if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
          pressed_reg <= ~pressed_reg;
          cnt_reg     <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign pressed = pressed_reg;
endmodule

// File: rtl/pwm_key_sequencer.sv
// Turns two debounced buttons into single-cycle duty step pulses with auto-repeat
// and a two-key "breathing" sweep, tracking a saturating mirror of the duty level.
module pwm_key_sequencer
  import pwm_key_sequencer_pkg::*;
#(
  parameter int CNT_NUM       = 8,
  parameter int DEBOUNCE_CYC  = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int SWEEP_PERIOD  = 50
) (
  input  logic clk,
  input  logic rst,
  pwm_key_sequencer_if.master bus
);
  localparam int W      = get_width(CNT_NUM + 1);
  localparam int T_MAX0 = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int T_MAX  = (T_MAX0 > SWEEP_PERIOD) ? T_MAX0 : SWEEP_PERIOD;
  localparam int TW     = get_width(T_MAX);

  localparam logic [W-1:0]  LVL_MAX   = W'(CNT_NUM);
  localparam logic [W-1:0]  LVL_INIT  = W'(CNT_NUM / 2);
  localparam logic [TW-1:0] T_DELAY   = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] T_REPEAT  = TW'(REPEAT_PERIOD - 1);
  localparam logic [TW-1:0] T_SWEEP   = TW'(SWEEP_PERIOD - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HOLD_UP  = 3'd1;
  localparam logic [2:0] S_REP_UP   = 3'd2;
  localparam logic [2:0] S_HOLD_DN  = 3'd3;
  localparam logic [2:0] S_REP_DN   = 3'd4;
  localparam logic [2:0] S_SWEEP_UP = 3'd5;
  localparam logic [2:0] S_SWEEP_DN = 3'd6;
  localparam logic [2:0] S_WAIT_REL = 3'd7;

  logic [1:0] btn_n;
  logic [1:0] pressed;
  logic       up_p;
  logic       dn_p;

  assign btn_n = {bus.btn_down_n, bus.btn_up_n};

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .btn_n   (btn_n[gi]),
      .pressed (pressed[gi])
    );
  end

  assign up_p = pressed[0];
  assign dn_p = pressed[1];

  logic [2:0]    state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [W-1:0]  level_reg, level_next;
  logic          sweep_reg, sweep_next;
  logic          key_up_reg, key_up_next;
  logic          key_down_reg, key_down_next;
  logic          step_up, step_dn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      level_reg    <= LVL_INIT;
      sweep_reg    <= 1'b0;
      key_up_reg   <= 1'b0;
      key_down_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      level_reg    <= level_next;
      sweep_reg    <= sweep_next;
      key_up_reg   <= key_up_next;
      key_down_reg <= key_down_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + TW'(1);
    sweep_next = sweep_reg;
    step_up    = 1'b0;
    step_dn    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        timer_next = '0;
        if (up_p && dn_p) begin
          sweep_next = 1'b1;
          state_next = S_WAIT_REL;
        end else if (up_p) begin
          step_up    = 1'b1;
          state_next = S_HOLD_UP;
        end else if (dn_p) begin
          step_dn    = 1'b1;
          state_next = S_HOLD_DN;
        end
      end
      S_HOLD_UP, S_REP_UP: begin
        if (up_p && dn_p) begin
          sweep_next = 1'b1;
          state_next = S_WAIT_REL;
        end else if (!up_p) begin
          state_next = S_IDLE;
        end else if (timer_reg == ((state_reg == S_HOLD_UP) ? T_DELAY : T_REPEAT)) begin
          step_up    = 1'b1;
          timer_next = '0;
          state_next = S_REP_UP;
        end
      end
      S_HOLD_DN, S_REP_DN: begin
        if (up_p && dn_p) begin
          sweep_next = 1'b1;
          state_next = S_WAIT_REL;
        end else if (!dn_p) begin
          state_next = S_IDLE;
        end else if (timer_reg == ((state_reg == S_HOLD_DN) ? T_DELAY : T_REPEAT)) begin
          step_dn    = 1'b1;
          timer_next = '0;
          state_next = S_REP_DN;
        end
      end
      // Turn around on the step that reaches the end, so the reverse step keeps the period.
      S_SWEEP_UP: begin
        if (up_p || dn_p) begin
          sweep_next = 1'b0;
          state_next = S_WAIT_REL;
        end else if (timer_reg == T_SWEEP) begin
          step_up    = 1'b1;
          timer_next = '0;
          if (level_reg >= LVL_MAX - W'(1)) state_next = S_SWEEP_DN;
        end
      end
      S_SWEEP_DN: begin
        if (up_p || dn_p) begin
          sweep_next = 1'b0;
          state_next = S_WAIT_REL;
        end else if (timer_reg == T_SWEEP) begin
          step_dn    = 1'b1;
          timer_next = '0;
          if (level_reg <= W'(1)) state_next = S_SWEEP_UP;
        end
      end
      S_WAIT_REL: begin
        timer_next = '0;
        if (!up_p && !dn_p) state_next = sweep_reg ? S_SWEEP_UP : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (state_next != state_reg) timer_next = '0;

    // Saturated steps are dropped here; the FSM timing above is unaffected.
    key_up_next   = step_up && (level_reg != LVL_MAX);
    key_down_next = step_dn && (level_reg != '0);
    level_next    = level_reg;
    if (key_up_next)   level_next = level_reg + W'(1);
    if (key_down_next) level_next = level_reg - W'(1);
  end

  assign bus.key_up       = key_up_reg;
  assign bus.key_down     = key_down_reg;
  assign bus.level        = level_reg;
  assign bus.sweep_active = sweep_reg;
endmodule

// File: doc/pwm_key_sequencer.md
# pwm_key_sequencer

Front-end controller for the PWM duty-cycle block: debounces two raw push-buttons and turns them into the single-cycle `key_up` / `key_down` step pulses the PWM block consumes. Holding a button produces auto-repeat steps, and pressing both buttons together toggles an autonomous "breathing" sweep that ramps the duty up and down without user input. It keeps a mirror of the duty level so it never issues a step the PWM block would saturate on.

## Interface
- `CNT_NUM`, 8: PWM period in cycles; duty level range is 0..CNT_NUM.
- `DEBOUNCE_CYC`, 20: consecutive stable cycles required to accept a button change.
- `REPEAT_DELAY`, 500: held cycles after the first step before auto-repeat starts.
- `REPEAT_PERIOD`, 100: cycles between auto-repeat steps.
- `SWEEP_PERIOD`, 50: cycles between steps in sweep mode.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `btn_up_n` in 1: raw up button, active-low, asynchronous to `clk`.
- `btn_down_n` in 1: raw down button, active-low, asynchronous.
- `key_up` out 1: one-cycle step-up pulse to the PWM block.
- `key_down` out 1: one-cycle step-down pulse to the PWM block.
- `level` out W: mirrored duty level. W = `get_width(CNT_NUM+1)`.
- `sweep_active` out 1: high while in sweep mode.

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer. The debounced "pressed" flag flips only after the synchronized value differs from it for `DEBOUNCE_CYC` consecutive cycles. Any glitch restarts the count.
- Control FSM states: IDLE, HOLD_UP, REP_UP, HOLD_DN, REP_DN, SWEEP_UP, SWEEP_DN, WAIT_REL.
- IDLE:
  - up pressed alone → emit up step, go to HOLD_UP.
  - down pressed alone → emit down step, go to HOLD_DN.
- HOLD_x: after `REPEAT_DELAY` cycles still held → REP_x. Release → IDLE.
- REP_x: one step every `REPEAT_PERIOD` cycles while held. Release → IDLE.
- Chord: the second key becoming pressed while the first is pressed (any non-sweep state) sets sweep mode and goes to WAIT_REL. No step is emitted on the chord cycle.
- WAIT_REL: wait until both keys are released, then enter SWEEP_UP if sweep was set, else IDLE.
- SWEEP_UP: one up step every `SWEEP_PERIOD` cycles. At `level == CNT_NUM` → SWEEP_DN.
- SWEEP_DN: one down step every `SWEEP_PERIOD` cycles. At `level == 0` → SWEEP_UP.
- Any key press during sweep clears sweep and goes to WAIT_REL. The press is consumed and no step is emitted.
- Saturation: an up step at `level == CNT_NUM` or a down step at `level == 0` is suppressed (no pulse, level unchanged). The FSM still follows its timing.
- `level` increments or decrements in the same cycle that `key_up` / `key_down` is registered high. It starts at `CNT_NUM/2`, which matches the PWM block's reset duty.
- `key_up` and `key_down` are never high in the same cycle. Both are registered outputs.

## Timing
- Reset values: `key_up` = 0, `key_down` = 0, `sweep_active` = 0, `level` = `CNT_NUM/2`, FSM = IDLE, debounced flags = released, all timers = 0.
- Press latency: the raw edge is stable from cycle 0, the debounced flag sets at cycle 2+`DEBOUNCE_CYC`, and the first `key_up` is high at cycle 3+`DEBOUNCE_CYC` for exactly 1 cycle.
- Auto-repeat: the first repeat pulse comes `REPEAT_DELAY` cycles after the first pulse. Subsequent pulses are spaced exactly `REPEAT_PERIOD` cycles.
- Sweep: the first step comes `SWEEP_PERIOD` cycles after entering SWEEP_UP. At the turnaround, the next step is in the opposite direction, `SWEEP_PERIOD` cycles after the last one.
- Timers reset on every state change.
- A reset assertion mid-pulse, mid-hold or mid-sweep drops all outputs to their reset values immediately (asynchronously).
- After deassertion, a button still held is treated as a new press only after a full debounce.

## Structure
- Use the shared util `get_width` for all counter widths. The timer width is `get_width` of the largest of `REPEAT_DELAY`, `REPEAT_PERIOD` and `SWEEP_PERIOD`.
- FSM state encodings go in a localparam block in the module. Nothing new is added to the shared package.
- One sub-module, `key_debounce` (synchronizer + debouncer, parameter `DEBOUNCE_CYC`), is instantiated twice.

## Test plan
Parameters for all scenarios: `CNT_NUM`=8, `DEBOUNCE_CYC`=4, `REPEAT_DELAY`=16, `REPEAT_PERIOD`=8, `SWEEP_PERIOD`=4.
- Reset then idle 50 cycles → no pulses, `level`=4, `sweep_active`=0.
- 2-cycle low glitch on `btn_up_n` → no pulse. Clean 10-cycle press → exactly one `key_up` at cycle 7 after the press, `level`=5.
- Hold down for 60 cycles → pulses at t0, t0+16, t0+24, t0+32, … and `level` stops at 0 with no pulse issued at 0.
- Chord both keys, release → `sweep_active`=1. `level` ramps 4→8→0→8 with steps every 4 cycles and one turnaround each end.
- Press up during sweep → `sweep_active`=0, no step emitted, `level` frozen.
- Assert `rst` during REP_UP with `level`=7 → outputs at reset values immediately and `level`=4.
